// File: rtl/banner_pkg.sv
// banner_pkg: shared state encoding, sizes and window helper
// for the seven-segment rotating banner blocks.
package banner_pkg;

  localparam int DIG_W        = 4;
  localparam int DISP_DIGITS  = 8;
  localparam int DISP_W       = DIG_W * DISP_DIGITS;
  localparam int BANNER_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Lower DISP_DIGITS digits of an ndig-digit banner rotated
  // left by pos digits. Bits above DIG_W*ndig must be zero,
  // and ndig must be at least DISP_DIGITS.
  function automatic logic [DISP_W-1:0] rotl_window(
    input logic [BANNER_MAX_W-1:0] banner,
    input int                      ndig,
    input logic [3:0]              pos
  );
    int sh;
    sh = DIG_W * int'(pos);
    return DISP_W'((banner << sh)
                 | (banner >> (DIG_W * ndig - sh)));
  endfunction

endpackage

// File: rtl/banner_tick_gen.sv
// banner_tick_gen: step-period counter, 0..DIV-1.
// Pulses o_step_tick during the last count while enabled.
module banner_tick_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_hold,
  input  logic i_clr,
  output logic o_step_tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_run;
  logic          w_last;

  assign w_run       = i_en & ~i_hold;
  assign w_last      = (r_cnt == LAST);
  assign o_step_tick = w_run & w_last;

  // Count while running, hold otherwise; clear wins over counting.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (w_run) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/banner_seq_ctrl.sv
// banner_seq_ctrl: rotating banner sequencer. Steps a 0..NDIG-1
// offset over a double-buffered banner and drives an 8-digit window.
module banner_seq_ctrl
  import banner_pkg::*;
#(
  parameter int NDIG     = 10,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic                    i_dir,
  input  logic                    i_pause,
  input  logic                    i_mode,
  input  logic                    i_load,
  input  logic [DIG_W*NDIG-1:0]   i_banner_in,
  output logic [DISP_W-1:0]       o_current_disp,
  output logic [3:0]              o_pos,
  output logic                    o_step_tick,
  output logic                    o_pass_done,
  output logic                    o_busy
);

  localparam int BW = DIG_W * NDIG;
  localparam logic [3:0] LAST_POS = 4'(NDIG - 1);

  state_t            r_state;
  state_t            w_nstate;
  logic [3:0]        r_pos;
  logic [3:0]        w_npos;
  logic [3:0]        r_step;
  logic [3:0]        w_nstep;
  logic [BW-1:0]     r_active;
  logic [BW-1:0]     w_nactive;
  logic [BW-1:0]     r_shadow;
  logic              r_pending;
  logic              w_npending;
  logic              w_copy;
  logic              w_pass;
  logic              r_pass_done;
  logic [DISP_W-1:0] r_disp;
  logic [DISP_W-1:0] w_ndisp;
  logic [3:0]        w_pos_inc;
  logic [3:0]        w_pos_dec;
  logic              w_tick;
  logic              w_cnt_en;
  logic              w_cnt_clr;

  assign w_cnt_en  = (r_state == ST_RUN) & i_en & ~rst;
  assign w_cnt_clr = (w_nstate == ST_IDLE) | (w_nstate == ST_DONE);

  banner_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_cnt_en),
    .i_hold      (i_pause),
    .i_clr       (w_cnt_clr),
    .o_step_tick (w_tick)
  );

  assign w_pos_inc = (r_pos == LAST_POS) ? 4'd0 : r_pos + 4'd1;
  assign w_pos_dec = (r_pos == 4'd0) ? LAST_POS : r_pos - 4'd1;

  // Next state, position, step count, load copy and window.
  always_comb begin
    w_nstate = r_state;
    w_npos   = r_pos;
    w_nstep  = r_step;
    w_copy   = 1'b0;
    w_pass   = 1'b0;
    if (!i_en) begin
      w_nstate = ST_IDLE;
      w_npos   = '0;
      w_nstep  = '0;
      w_copy   = r_pending
               & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_nstate = ST_RUN;
          w_npos   = '0;
          w_nstep  = '0;
          w_copy   = r_pending;
        end
        ST_RUN: begin
          if (i_pause) begin
            w_nstate = ST_PAUSED;
          end else if (w_tick) begin
            w_npos  = i_dir ? w_pos_inc : w_pos_dec;
            w_copy  = r_pending;
            w_nstep = (r_step == LAST_POS) ? 4'd0 : r_step + 4'd1;
            if (i_mode && (r_step == LAST_POS)) begin
              w_nstate = ST_DONE;
              w_npos   = '0;
              w_pass   = 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (!i_pause) begin
            w_nstate = ST_RUN;
          end
        end
        ST_DONE: begin
          // A load in DONE restarts the pass with the new banner.
          if (r_pending) begin
            w_copy   = 1'b1;
            w_nstate = ST_RUN;
            w_npos   = '0;
            w_nstep  = '0;
          end
        end
        default: begin
          w_nstate = ST_IDLE;
        end
      endcase
    end
    w_nactive  = w_copy ? r_shadow : r_active;
    w_npending = i_load | (r_pending & ~w_copy);
    if (w_nstate == ST_IDLE) begin
      w_ndisp = '0;
    end else begin
      w_ndisp = rotl_window(BANNER_MAX_W'(w_nactive), NDIG, w_npos);
    end
  end

  // State, position, banner buffers and window register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pos       <= '0;
      r_step      <= '0;
      r_active    <= '0;
      r_shadow    <= '0;
      r_pending   <= 1'b0;
      r_disp      <= '0;
      r_pass_done <= 1'b0;
    end else begin
      r_state     <= w_nstate;
      r_pos       <= w_npos;
      r_step      <= w_nstep;
      r_active    <= w_nactive;
      r_pending   <= w_npending;
      r_disp      <= w_ndisp;
      r_pass_done <= w_pass;
      if (i_load) begin
        r_shadow <= i_banner_in;
      end
    end
  end

  assign o_current_disp = r_disp;
  assign o_pos          = r_pos;
  assign o_step_tick    = w_tick;
  assign o_pass_done    = r_pass_done;
  assign o_busy         = (r_state == ST_RUN) | (r_state == ST_PAUSED);

endmodule

// File: tb/tb_banner_seq_ctrl.sv
// tb_banner_seq_ctrl: directed bench for banner_seq_ctrl with a
// step scoreboard checked by an independent monitor.
module tb_banner_seq_ctrl;

  typedef struct packed {
    logic [3:0]  pos;
    logic [31:0] disp;
    logic [7:0]  gap;
    logic        pass;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        dir;
  logic        pause;
  logic        mode;
  logic        load;
  logic [39:0] banner;
  logic [31:0] disp;
  logic [3:0]  pos;
  logic        step_tick;
  logic        pass_done;
  logic        busy;

  int   n_chk;
  int   n_fail;
  int   cyc_n;
  int   tick_cnt;
  int   pass_cnt;
  int   last_tick;
  int   last_gap;
  logic post_tick;
  exp_t exp_q[$];
  exp_t e;
  int   t0;
  int   p0;

  logic [31:0] win_b [10] = '{
    32'h23456789, 32'h34567890, 32'h45678901, 32'h56789012,
    32'h67890123, 32'h78901234, 32'h89012345, 32'h90123456,
    32'h01234567, 32'h12345678
  };

  banner_seq_ctrl #(
    .NDIG     (10),
    .TICK_DIV (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_en           (en),
    .i_dir          (dir),
    .i_pause        (pause),
    .i_mode         (mode),
    .i_load         (load),
    .i_banner_in    (banner),
    .o_current_disp (disp),
    .o_pos          (pos),
    .o_step_tick    (step_tick),
    .o_pass_done    (pass_done),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
    end
  endtask

  task automatic push(input logic [3:0] p, input logic [31:0] d,
                      input logic [7:0] g, input logic ps);
    exp_t x;
    x.pos  = p;
    x.disp = d;
    x.gap  = g;
    x.pass = ps;
    exp_q.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic after_tick();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (step_tick) got = 1'b1;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL tick_timeout: no step_tick in 20 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: the cycle after each step_tick, pop and compare.
  always @(negedge clk) begin
    if (post_tick) begin
      post_tick = 1'b0;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_step: pos=%0d disp=0x%08h",
                 pos, disp);
      end else begin
        e = exp_q.pop_front();
        chk("step_pos", 32'(pos), 32'(e.pos));
        chk("step_disp", disp, e.disp);
        chk("step_pass_done", 32'(pass_done), 32'(e.pass));
        if (e.gap != 0) chk("step_gap", 32'(last_gap), 32'(e.gap));
      end
    end
    if (step_tick) begin
      tick_cnt++;
      last_gap  = cyc_n - last_tick;
      last_tick = cyc_n;
      post_tick = 1'b1;
    end
    if (pass_done) pass_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc_n = 0; tick_cnt = 0;
    pass_cnt = 0; last_tick = 0; last_gap = 0; post_tick = 1'b0;
    rst = 1'b1; en = 1'b0; dir = 1'b1; pause = 1'b0;
    mode = 1'b0; load = 1'b0; banner = '0;
    cyc(2);
    chk("rst_disp", disp, 32'h0);
    chk("rst_pos", 32'(pos), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_step_tick", 32'(step_tick), 32'h0);
    chk("rst_pass_done", 32'(pass_done), 32'h0);
    rst = 1'b0;

    load = 1'b1; banner = 40'h0123456789;
    cyc(1);
    load = 1'b0; banner = '0;
    cyc(1);
    chk("idle_blank", disp, 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    en = 1'b1; dir = 1'b1; mode = 1'b0;
    for (int i = 1; i <= 10; i++)
      push(4'(i % 10), win_b[i % 10], (i == 1) ? 8'd0 : 8'd4, 1'b0);
    cyc(1);
    chk("first_disp", disp, 32'h23456789);
    chk("first_pos", 32'(pos), 32'h0);
    chk("first_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 10; i++) after_tick();

    push(4'd9, win_b[9], 8'd4, 1'b0);
    dir = 1'b0;
    after_tick();
    cyc(2);
    dir = 1'b1;
    cyc(1);
    chk("dir_flip_hold_pos", 32'(pos), 32'd9);
    push(4'd0, win_b[0], 8'd4, 1'b0);
    after_tick();
    push(4'd1, win_b[1], 8'd4, 1'b0);
    after_tick();
    cyc(1);
    en = 1'b0;
    cyc(1);
    chk("en_off_disp", disp, 32'h0);
    chk("en_off_pos", 32'(pos), 32'h0);
    chk("en_off_busy", 32'(busy), 32'h0);

    t0 = tick_cnt; p0 = pass_cnt;
    mode = 1'b1; en = 1'b1;
    for (int i = 1; i <= 9; i++)
      push(4'(i), win_b[i], (i == 1) ? 8'd0 : 8'd4, 1'b0);
    push(4'd0, win_b[0], 8'd4, 1'b1);
    for (int i = 0; i < 10; i++) after_tick();
    chk("done_busy", 32'(busy), 32'h0);
    chk("done_pos", 32'(pos), 32'h0);
    chk("done_disp", disp, 32'h23456789);
    cyc(8);
    chk("pass_tick_count", 32'(tick_cnt - t0), 32'd10);
    chk("pass_done_count", 32'(pass_cnt - p0), 32'd1);
    chk("done_disp_hold", disp, 32'h23456789);

    en = 1'b0;
    cyc(1);
    en = 1'b1; mode = 1'b0;
    push(4'd1, win_b[1], 8'd0, 1'b0);
    push(4'd2, win_b[2], 8'd4, 1'b0);
    push(4'd3, win_b[3], 8'd4, 1'b0);
    for (int i = 0; i < 3; i++) after_tick();
    cyc(1);
    load = 1'b1; banner = 40'h1111111111;
    cyc(1);
    banner = 40'hAAAAABBBBB;
    cyc(1);
    load = 1'b0; banner = '0;
    chk("load_hold_disp", disp, win_b[3]);
    push(4'd4, 32'hBBBBAAAA, 8'd4, 1'b0);
    after_tick();
    push(4'd5, 32'hBBBAAAAA, 8'd4, 1'b0);
    push(4'd6, 32'h76FEDCBA, 8'd4, 1'b0);
    cyc(3);
    load = 1'b1; banner = 40'hFEDCBA9876;
    after_tick();
    load = 1'b0; banner = '0;
    after_tick();

    push(4'd7, 32'h6FEDCBA9, 8'd12, 1'b0);
    cyc(2);
    pause = 1'b1;
    cyc(4);
    chk("pause_pos", 32'(pos), 32'd6);
    chk("pause_disp", disp, 32'h76FEDCBA);
    chk("pause_busy", 32'(busy), 32'h1);
    cyc(3);
    pause = 1'b0;
    after_tick();

    pause = 1'b1;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk("rst_paused_disp", disp, 32'h0);
    chk("rst_paused_pos", 32'(pos), 32'h0);
    chk("rst_paused_busy", 32'(busy), 32'h0);
    chk("rst_paused_step", 32'(step_tick), 32'h0);
    chk("rst_paused_pass", 32'(pass_done), 32'h0);
    rst = 1'b0; pause = 1'b0;
    cyc(1);
    chk("post_rst_busy", 32'(busy), 32'h1);
    chk("post_rst_banner_clear", disp, 32'h0);
    en = 1'b0;
    cyc(4);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    chk("total_pass_done", 32'(pass_cnt), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/banner_seq_ctrl.md
Name: banner_seq_ctrl

Overview:
- Sequencer for the seven-segment rotating banner.
- Generates its own step tick from the system clock and keeps a 0..9 rotation position with direction control.
- Supports loop or single-pass modes, pause, and a double-buffered banner load; it drives the 32-bit (8-digit) display window from a 40-bit (10-digit) banner.
- Sits between the board I/O (switches, debounced buttons) and the seven-segment multiplexer.

Parameters:
- NDIG, 10, banner length in 4-bit digits; the banner is 4*NDIG = 40 bits.
- TICK_DIV, 50_000_000, clk cycles per rotation step; must be ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; low forces IDLE and a blank display.
- dir  in  1  1 = pos increments, 0 = pos decrements.
- pause  in  1  level; freezes position and tick counter.
- mode  in  1  0 = continuous loop, 1 = single pass.
- load  in  1  one-cycle pulse; captures banner_in.
- banner_in  in  40  new banner digits; digit k occupies bits [4k+3:4k].
- current_disp  out  32  display window.
- pos  out  4  current rotation offset, 0..9.
- step_tick  out  1  one-cycle pulse per step boundary.
- pass_done  out  1  one-cycle pulse when a single pass completes.
- busy  out  1  high in RUN or PAUSED.

Behaviour:
- Reset, applied in the same cycle as rst:
  - state=IDLE, pos=0, tick counter=0.
  - active banner=0, shadow banner=0, pending=0.
  - current_disp=0, step_tick=0, pass_done=0, busy=0.
- Window function:
  - current_disp = lower 32 bits of (active banner rotated left by 4*pos bits).
  - pos=0 gives banner[31:0]; pos=1 gives {banner[27:0],banner[39:36]}; pos=9 gives banner[35:4].
  - current_disp is registered. It updates in the same cycle that pos and the active banner update, so there is no extra latency.
- Load:
  - A load pulse copies banner_in to the shadow register and sets pending.
  - In IDLE or DONE, the shadow is copied to the active banner on the next cycle and pending clears.
  - In RUN or PAUSED, the copy happens only on a step_tick. That step shows the new banner at the new pos.
  - A second load before the copy overwrites the shadow; the last value wins.
- Tick:
  - The counter runs only in RUN with pause=0, counting 0..TICK_DIV-1.
  - At TICK_DIV-1 the counter wraps to 0 and step_tick is high for that cycle.
  - On the same edge, pos steps: dir=1 gives pos+1 with 9→0; dir=0 gives pos-1 with 0→9.
- States:
  - IDLE: display blank. en=1 moves to RUN with pos=0 and counter=0; the window is shown from the next cycle.
  - RUN: steps on tick. pause=1 moves to PAUSED.
  - RUN, mode=1: after the 10th step since entering RUN (pos back to 0), move to DONE and pulse pass_done in the cycle pos reaches 0.
  - PAUSED: pos, counter and display held. pause=0 returns to RUN and the counter resumes from its held value.
  - DONE: display held at pos=0. A load, or en toggling low then high, restarts the pass. Re-entering RUN resets pos to 0 and the step count.
  - en=0 in any state: IDLE on the next edge, with current_disp=0, pos=0 and counter=0. A pending load is kept.
- dir and mode are sampled only at step boundaries, so a change takes effect on the next tick.
- A mode change 1→0 mid-pass gives continuous looping.
- Priority: rst > en=0 > pause > tick > load copy. A load pulse on the same cycle as a tick is captured into the shadow and applied at the following tick.
- The step count is a 4-bit counter that resets on RUN entry and is not reset by PAUSED.

Decomposition:
- Shared package banner_pkg:
  - state encoding: IDLE, RUN, PAUSED, DONE.
  - DIG_W=4, DISP_DIGITS=8.
  - function rotl_window(banner, pos), shared with any future banner blocks.
- One sub-module, banner_tick_gen: parameterised counter with enable and hold inputs and a step_tick output.
- The FSM, load buffer and window register stay in banner_seq_ctrl.

Test Plan (TICK_DIV=4, banner 0x0123456789):
- rst, then en=1, dir=1, mode=0 → first disp 0x23456789; after tick 1 (cycle 4) disp 0x34567890, pos=1; after 10 ticks pos=0, disp 0x23456789; step_tick every 4 cycles.
- dir=0 from pos=0 → next tick pos=9, disp 0x12345678 (= banner[35:4]); a dir flip mid-period takes effect only at the next tick.
- mode=1 → exactly 10 step_ticks, pass_done a single pulse in the cycle pos reaches 0, then busy=0 and the display holds 0x23456789.
- pause=1 for 7 cycles mid-period (counter=2) → pos and disp frozen; after release the tick arrives 2 cycles later, not 4.
- load 0xAAAAABBBBB at pos=3 mid-period → disp unchanged until the tick, then disp = window of the new banner at pos=4; load coincident with tick → applied one tick later.
- en=0 during RUN → next cycle current_disp=0, pos=0, busy=0; rst asserted mid-PAUSED → all outputs 0 in the same cycle.
